// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter.
// Owner tags for read return, arbiter states, default starvation limit.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_e;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_LOCK_M0 = 1'b1
   } state_e;

   localparam int STARVE_MAX_DEF = 8;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating starvation counter for the debug/DMA requester.
// Clear has priority over increment.
module dmem_starve_cnt #(
   parameter int MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_inc,
   input  logic       i_clr,
   output logic [7:0] o_cnt,
   output logic       o_sat
);

   localparam logic [7:0] LP_MAX = 8'(MAX);

   logic [7:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != LP_MAX)) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign o_cnt = r_cnt;
   assign o_sat = (r_cnt == LP_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: core (M0) vs debug/DMA (M1).
// Keeps core RMW pairs atomic and bounds M1 waiting time.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req_i,
   input  logic          m0_we_i,
   input  logic [AW-1:0] m0_addr_i,
   input  logic [DW-1:0] m0_wdata_i,
   input  logic          m0_lock_i,
   output logic [DW-1:0] m0_rdata_o,
   output logic          m0_rvalid_o,
   output logic          m0_hold_o,
   input  logic          m1_req_i,
   input  logic          m1_we_i,
   input  logic [AW-1:0] m1_addr_i,
   input  logic [DW-1:0] m1_wdata_i,
   output logic          m1_gnt_o,
   output logic [DW-1:0] m1_rdata_o,
   output logic          m1_rvalid_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i
);

   state_e        r_state;
   state_e        w_state_nxt;
   owner_e        r_rd_owner;
   owner_e        w_rd_owner_nxt;
   logic          w_gnt_m0;
   logic          w_gnt_m1;
   logic          w_sat;
   logic [7:0]    w_starve_cnt;
   logic          r_m0_rvalid;
   logic          r_m1_rvalid;
   logic [DW-1:0] r_m0_rdata;
   logic [DW-1:0] r_m1_rdata;

   dmem_starve_cnt #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .clk   (clk),
      .rst   (rst),
      .i_inc (m1_req_i & ~w_gnt_m1),
      .i_clr (w_gnt_m1 | ~m1_req_i),
      .o_cnt (w_starve_cnt),
      .o_sat (w_sat)
   );

   // A saturated M1 only wins outside a locked RMW pair.
   always_comb begin
      w_gnt_m0 = 1'b0;
      w_gnt_m1 = 1'b0;
      if (!rst) begin
         if (r_state == ST_LOCK_M0) begin
            w_gnt_m0 = 1'b1;
         end else if (m1_req_i && w_sat) begin
            w_gnt_m1 = 1'b1;
         end else if (m0_req_i) begin
            w_gnt_m0 = 1'b1;
         end else if (m1_req_i) begin
            w_gnt_m1 = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_gnt_m0 && m0_lock_i) begin
               w_state_nxt = ST_LOCK_M0;
            end
         end
         ST_LOCK_M0: begin
            if (!m0_lock_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_o     = '0;
      mem_wdata_o    = '0;
      w_rd_owner_nxt = OWN_NONE;
      if (w_gnt_m0) begin
         mem_req_o   = 1'b1;
         mem_we_o    = m0_we_i;
         mem_addr_o  = m0_addr_i;
         mem_wdata_o = m0_wdata_i;
         if (!m0_we_i) begin
            w_rd_owner_nxt = OWN_M0;
         end
      end else if (w_gnt_m1) begin
         mem_req_o   = 1'b1;
         mem_we_o    = m1_we_i;
         mem_addr_o  = m1_addr_i;
         mem_wdata_o = m1_wdata_i;
         if (!m1_we_i) begin
            w_rd_owner_nxt = OWN_M1;
         end
      end
   end

   assign m0_hold_o = m0_req_i & ~w_gnt_m0 & ~rst;
   assign m1_gnt_o  = w_gnt_m1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_rd_owner  <= OWN_NONE;
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
         r_m0_rdata  <= '0;
         r_m1_rdata  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rd_owner  <= w_rd_owner_nxt;
         r_m0_rvalid <= (r_rd_owner == OWN_M0);
         r_m1_rvalid <= (r_rd_owner == OWN_M1);
         if (r_rd_owner == OWN_M0) begin
            r_m0_rdata <= mem_rdata_i;
         end
         if (r_rd_owner == OWN_M1) begin
            r_m1_rdata <= mem_rdata_i;
         end
      end
   end

   assign m0_rvalid_o = r_m0_rvalid;
   assign m1_rvalid_o = r_m1_rvalid;
   assign m0_rdata_o  = r_m0_rdata;
   assign m1_rdata_o  = r_m1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then constrained random traffic,
// checked against a slot-level reference model with its own RAM image.
module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SM = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          m0_req_i = 1'b0;
   logic          m0_we_i = 1'b0;
   logic [AW-1:0] m0_addr_i = '0;
   logic [DW-1:0] m0_wdata_i = '0;
   logic          m0_lock_i = 1'b0;
   logic [DW-1:0] m0_rdata_o;
   logic          m0_rvalid_o;
   logic          m0_hold_o;
   logic          m1_req_i = 1'b0;
   logic          m1_we_i = 1'b0;
   logic [AW-1:0] m1_addr_i = '0;
   logic [DW-1:0] m1_wdata_i = '0;
   logic          m1_gnt_o;
   logic [DW-1:0] m1_rdata_o;
   logic          m1_rvalid_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;

   dmem_arbiter #(
      .AW         (AW),
      .DW         (DW),
      .STARVE_MAX (SM)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .m0_req_i    (m0_req_i),
      .m0_we_i     (m0_we_i),
      .m0_addr_i   (m0_addr_i),
      .m0_wdata_i  (m0_wdata_i),
      .m0_lock_i   (m0_lock_i),
      .m0_rdata_o  (m0_rdata_o),
      .m0_rvalid_o (m0_rvalid_o),
      .m0_hold_o   (m0_hold_o),
      .m1_req_i    (m1_req_i),
      .m1_we_i     (m1_we_i),
      .m1_addr_i   (m1_addr_i),
      .m1_wdata_i  (m1_wdata_i),
      .m1_gnt_o    (m1_gnt_o),
      .m1_rdata_o  (m1_rdata_o),
      .m1_rvalid_o (m1_rvalid_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   always #5 clk = ~clk;

   // RAM seen by the DUT
   logic [DW-1:0] ram [0:511];
   logic [DW-1:0] r_rdq = '0;
   assign mem_rdata_i = r_rdq;

   always @(posedge clk) begin
      if (mem_req_o && !mem_we_o) r_rdq <= ram[mem_addr_o[8:0]];
      if (mem_req_o && mem_we_o) ram[mem_addr_o[8:0]] <= mem_wdata_o;
   end

   // reference model state
   typedef struct {
      int          due;
      int          who;
      logic [31:0] data;
   } rd_t;

   logic [DW-1:0] ref_ram [0:511];
   rd_t           pend[$];
   int            cyc = 0;
   bit            mdl_lock = 0;
   int            mdl_wait = 0;
   bit            ev0 = 0, ev1 = 0;
   logic [31:0]   erd0 = '0, erd1 = '0;
   bit            last_g1 = 0;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // one cycle: inputs already driven, called at negedge
   task automatic step(input bit r);
      bit g0, g1;
      logic [31:0] ea, ed;
      bit ew;
      rd_t keep[$];
      rst = r;
      #1;
      g0 = 0;
      g1 = 0;
      if (!r) begin
         if (mdl_lock) g0 = 1;
         else if (m1_req_i && mdl_wait >= SM) g1 = 1;
         else if (m0_req_i) g0 = 1;
         else if (m1_req_i) g1 = 1;
      end
      ew = g0 ? m0_we_i : (g1 ? m1_we_i : 1'b0);
      ea = g0 ? m0_addr_i : (g1 ? m1_addr_i : '0);
      ed = g0 ? m0_wdata_i : (g1 ? m1_wdata_i : '0);
      chk("mem_req", 32'(mem_req_o), 32'(g0 | g1));
      chk("mem_we", 32'(mem_we_o), 32'(ew));
      chk("mem_addr", mem_addr_o, ea);
      chk("mem_wdata", mem_wdata_o, ed);
      chk("m1_gnt", 32'(m1_gnt_o), 32'(g1));
      chk("m0_hold", 32'(m0_hold_o), 32'(!r && m0_req_i && !g0));
      chk("m0_rvalid", 32'(m0_rvalid_o), 32'(ev0));
      chk("m1_rvalid", 32'(m1_rvalid_o), 32'(ev1));
      chk("m0_rdata", m0_rdata_o, erd0);
      chk("m1_rdata", m1_rdata_o, erd1);
      last_g1 = g1;
      @(posedge clk);
      cyc++;
      ev0 = 0;
      ev1 = 0;
      if (r) begin
         mdl_lock = 0;
         mdl_wait = 0;
         pend.delete();
         erd0 = '0;
         erd1 = '0;
      end else begin
         if ((g0 || g1) && !ew) begin
            pend.push_back('{cyc + 1, g0 ? 0 : 1, ref_ram[ea[8:0]]});
         end
         if ((g0 || g1) && ew) ref_ram[ea[8:0]] = ed;
         mdl_lock = g0 && m0_lock_i;
         if (m1_req_i && !g1) mdl_wait = (mdl_wait < SM) ? mdl_wait + 1 : SM;
         else mdl_wait = 0;
         foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
               if (pend[i].who == 0) begin
                  ev0 = 1;
                  erd0 = pend[i].data;
               end else begin
                  ev1 = 1;
                  erd1 = pend[i].data;
               end
            end else begin
               keep.push_back(pend[i]);
            end
         end
         pend = keep;
      end
      @(negedge clk);
   endtask

   task automatic m0(input bit rq, input bit we, input logic [31:0] a,
                     input logic [31:0] d, input bit lk);
      m0_req_i = rq;
      m0_we_i = we;
      m0_addr_i = a;
      m0_wdata_i = d;
      m0_lock_i = lk;
   endtask

   task automatic m1(input bit rq, input bit we, input logic [31:0] a,
                     input logic [31:0] d);
      m1_req_i = rq;
      m1_we_i = we;
      m1_addr_i = a;
      m1_wdata_i = d;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         ram[i] = 32'(i) * 32'h01010101 ^ 32'hA5A50000;
         ref_ram[i] = ram[i];
      end
      ram[256] = 32'hDEADBEEF;
      ref_ram[256] = 32'hDEADBEEF;
      rst = 1;
      @(posedge clk);
      @(negedge clk);

      // reset with both requesting
      m0(1, 0, 32'h100, 0, 0);
      m1(1, 0, 32'h104, 0);
      repeat (3) step(1);

      // single M0 read
      m1(0, 0, 0, 0);
      m0(1, 0, 32'h100, 0, 0);
      step(0);
      m0(0, 0, 0, 0, 0);
      repeat (3) step(0);
      chk("dir_m0_rdata", m0_rdata_o, 32'hDEADBEEF);

      // continuous contention
      m0(1, 0, 32'h104, 0, 0);
      m1(1, 0, 32'h108, 0);
      repeat (12) step(0);

      // RMW lock with M1 waiting
      m1(0, 0, 0, 0);
      m0(0, 0, 0, 0, 0);
      step(0);
      m1(1, 1, 32'h10C, 32'hCAFE0001);
      m0(1, 0, 32'h110, 0, 0);
      repeat (2) step(0);
      m0(1, 0, 32'h110, 0, 1);
      step(0);
      m0(1, 1, 32'h110, 32'h12345678, 0);
      step(0);
      m0(0, 0, 0, 0, 0);
      repeat (4) step(0);
      chk("dir_rmw_ram", ram[272], 32'h12345678);

      // M1 alone: three writes then a read
      m1(0, 0, 0, 0);
      step(0);
      m1(1, 1, 32'h120, 32'h11111111);
      step(0);
      m1(1, 1, 32'h121, 32'h22222222);
      step(0);
      m1(1, 1, 32'h122, 32'h33333333);
      step(0);
      m1(1, 0, 32'h121, 0);
      step(0);
      m1(0, 0, 0, 0);
      repeat (3) step(0);
      chk("dir_m1_rdata", m1_rdata_o, 32'h22222222);

      // reset in the middle of an RMW pair
      m0(1, 0, 32'h100, 0, 1);
      step(0);
      m0(1, 1, 32'h100, 32'h0BADF00D, 1);
      step(1);
      m0(0, 0, 0, 0, 0);
      m1(1, 0, 32'h100, 0);
      step(0);
      m1(0, 0, 0, 0);
      repeat (3) step(0);

      // constrained random traffic
      for (int i = 0; i < 600; i++) begin
         bit rq0;
         bit lk;
         rq0 = mdl_lock || ($urandom_range(0, 2) != 0);
         lk = rq0 && ($urandom_range(0, 3) == 0);
         m0(rq0, $urandom_range(0, 1) == 1, 32'h100 + $urandom_range(0, 15),
            $urandom, lk);
         if (!m1_req_i || last_g1) begin
            m1($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
               32'h100 + $urandom_range(0, 15), $urandom);
         end
         step($urandom_range(0, 79) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
